// File: rtl/stitch_pipeline_bp.sv
// rtl/stitch_pipeline_bp.sv - elastic add-2^k pipeline with bubble-collapsing backpressure
module stitch_pipeline_bp #(
  parameter int WIDTH      = 32,
  parameter int STAGES     = 2,
  parameter int RESET_DATA = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WIDTH-1:0]              in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(STAGES+2)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(STAGES+2);

  logic [WIDTH-1:0] r_data [0:STAGES];
  logic [STAGES:0]  r_valid;
  logic [STAGES:0]  w_en;
  logic [WIDTH-1:0] w_up_data  [0:STAGES];
  logic             w_up_valid [0:STAGES];
  logic [OCC_W-1:0] w_occ;

  // A level may advance when it is empty or the level after it advances.
  always_comb begin
    w_en = '0;
    w_en[STAGES] = !r_valid[STAGES] || out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      w_en[i] = !r_valid[i] || w_en[i+1];
    end
  end

  assign w_up_data[0]  = in_data;
  assign w_up_valid[0] = in_valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    assign w_up_data[k+1]  = r_data[k] + (WIDTH'(1) << k);
    assign w_up_valid[k+1] = r_valid[k];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i <= STAGES; i++) begin
        if (w_en[i]) r_valid[i] <= w_up_valid[i];
      end
    end
  end

  // Data only moves with a real item, so bubbles leave registers untouched.
  always_ff @(posedge clk) begin
    for (int i = 0; i <= STAGES; i++) begin
      if (!rst_n) begin
        if (RESET_DATA != 0) r_data[i] <= '0;
      end else if (w_en[i] && w_up_valid[i]) begin
        r_data[i] <= w_up_data[i];
      end
    end
  end

  always_comb begin
    w_occ = '0;
    for (int i = 0; i <= STAGES; i++) begin
      w_occ = w_occ + OCC_W'(r_valid[i]);
    end
  end

  assign in_ready  = rst_n && w_en[0];
  assign out_data  = r_data[STAGES];
  assign out_valid = r_valid[STAGES];
  assign occupancy = w_occ;

endmodule

// File: tb/tb_stitch_pipeline_bp.sv
// tb/tb_stitch_pipeline_bp.sv - self-checking bench with queue model for stitch_pipeline_bp
module tb_stitch_pipeline_bp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a_in_data, a_out_data;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [1:0]  a_occ;
  logic [3:0]  b_in_data, b_out_data;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [2:0]  b_occ;

  int checks = 0;
  int failures = 0;
  bit mdl_on = 1'b0;
  logic [63:0] qa [$];
  logic [63:0] qb [$];

  always #5 clk = ~clk;

  stitch_pipeline_bp #(.WIDTH(32), .STAGES(2), .RESET_DATA(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .occupancy(a_occ)
  );

  stitch_pipeline_bp #(.WIDTH(4), .STAGES(3), .RESET_DATA(0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .occupancy(b_occ)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Whole pipeline adds 2^STAGES-1 modulo 2^WIDTH.
  function automatic logic [63:0] exp_a(input logic [63:0] x);
    return (x + 64'd3) & 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] exp_b(input logic [63:0] x);
    return (x + 64'd7) & 64'hF;
  endfunction

  // Model: FIFO of accepted items; occupancy equals items in flight,
  // input blocks only when every level holds an item and output stalls.
  always @(negedge clk) begin
    if (mdl_on) begin
      chk("a_in_ready", a_in_ready, rst_n && (qa.size() < 3 || a_out_ready));
      chk("a_occupancy", a_occ, qa.size());
      if (a_out_valid) begin
        chk("a_out_nonempty", qa.size() != 0, 1);
        if (qa.size() != 0) chk("a_out_data", a_out_data, exp_a(qa[0]));
      end
      chk("b_in_ready", b_in_ready, rst_n && (qb.size() < 4 || b_out_ready));
      chk("b_occupancy", b_occ, qb.size());
      if (b_out_valid) begin
        chk("b_out_nonempty", qb.size() != 0, 1);
        if (qb.size() != 0) chk("b_out_data", b_out_data, exp_b(qb[0]));
      end
      if (!rst_n) begin
        qa.delete();
        qb.delete();
      end else begin
        if (a_out_valid && a_out_ready && qa.size() != 0) void'(qa.pop_front());
        if (a_in_valid && a_in_ready) qa.push_back(64'(a_in_data));
        if (b_out_valid && b_out_ready && qb.size() != 0) void'(qb.pop_front());
        if (b_in_valid && b_in_ready) qb.push_back(64'(b_in_data));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    a_in_data = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_in_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    repeat (2) tick();
    mdl_on = 1'b1;
    @(negedge clk);
    chk("rst_a_valid", a_out_valid, 0);
    chk("rst_a_occ", a_occ, 0);
    chk("rst_a_data", a_out_data, 0);
    chk("rst_a_in_ready", a_in_ready, 0);
    chk("rst_b_valid", b_out_valid, 0);
    chk("rst_b_occ", b_occ, 0);
    tick();
    rst_n = 1'b1;

    // Latency: accept 5 at edge t, visible after edge t+2 as 8.
    a_out_ready = 1'b1;
    a_in_data = 32'h5; a_in_valid = 1'b1;
    @(negedge clk);
    chk("lat_in_ready", a_in_ready, 1);
    tick();
    a_in_valid = 1'b0;
    @(negedge clk); chk("lat_t0_valid", a_out_valid, 0);
    tick();
    @(negedge clk); chk("lat_t1_valid", a_out_valid, 0);
    tick();
    @(negedge clk);
    chk("lat_t2_valid", a_out_valid, 1);
    chk("lat_t2_data", a_out_data, 32'h8);
    tick();

    // Wraparound with carry discarded.
    a_in_data = 32'hFFFF_FFFE; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("wrap_valid", a_out_valid, 1);
    chk("wrap_data", a_out_data, 32'h1);
    tick();

    // Full pipeline streaming at one item per cycle.
    a_in_valid = 1'b1; a_in_data = $urandom;
    repeat (3) begin tick(); a_in_data = $urandom; end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stream_occ", a_occ, 3);
      chk("stream_in_ready", a_in_ready, 1);
      chk("stream_valid", a_out_valid, 1);
      tick();
      a_in_data = $urandom;
    end

    // Stall full, then reset discards in-flight items.
    a_out_ready = 1'b0;
    tick();
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("full_occ", a_occ, 3);
    chk("full_in_ready", a_in_ready, 0);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_ready", a_in_ready, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", a_out_valid, 0);
    chk("rst_mid_occ", a_occ, 0);
    chk("rst_mid_data", a_out_data, 0);
    tick();
    a_out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_no_emit", a_out_valid, 0);
      tick();
    end

    // STAGES=3 stalled fill: four accepted, fifth blocked, then drained in order.
    b_out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      b_in_data = 4'(k); b_in_valid = 1'b1;
      @(negedge clk);
      chk("b_fill_in_ready", b_in_ready, 1);
      tick();
    end
    b_in_data = 4'd5;
    @(negedge clk);
    chk("b_full_in_ready", b_in_ready, 0);
    chk("b_full_occ", b_occ, 4);
    chk("b_full_valid", b_out_valid, 1);
    tick();
    b_out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("b_drain_valid", b_out_valid, 1);
      chk("b_drain_data", b_out_data, 64'(8 + k));
      tick();
      b_in_valid = 1'b0;
    end

    // Random traffic, 50% valid and 50% ready on both instances.
    for (int c = 0; c < 20000; c++) begin
      a_in_valid  = 1'($urandom_range(0, 1));
      a_out_ready = 1'($urandom_range(0, 1));
      a_in_data   = $urandom;
      b_in_valid  = 1'($urandom_range(0, 1));
      b_out_ready = 1'($urandom_range(0, 1));
      b_in_data   = 4'($urandom);
      tick();
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    chk("drain_a_occ", a_occ, 0);
    chk("drain_b_occ", b_occ, 0);
    #1;
    mdl_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
